multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl_pkg.sv | 61 ++++++
 rtl/multicycle_ctrl_alu_decoder.sv | 38 +++
 rtl/multicycle_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle RV32I controller: ALU operation codes,
// FSM state encodings, opcodes and datapath mux select encodings.
package multicycle_ctrl_pkg;

  // ALU operation codes; bit0 = 1 selects the ALU subtract path
  localparam logic [2:0] ALU_CTRL_ADD = 3'b000;
  localparam logic [2:0] ALU_CTRL_SUB = 3'b001;
  localparam logic [2:0] ALU_CTRL_AND = 3'b010;
  localparam logic [2:0] ALU_CTRL_OR  = 3'b011;
  localparam logic [2:0] ALU_CTRL_SLT = 3'b101;

  // ALUOp from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  // Opcodes
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps ALUOp/funct3/funct7b5/op[5] to ALUControl and flags
// funct3 values this ALU cannot execute.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  // Fixed ops pass straight through; decoded ops follow funct3
  always_comb begin
    ALUControl = ALU_CTRL_ADD;
    illegal    = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_CTRL_ADD;
      ALUOP_SUB: ALUControl = ALU_CTRL_SUB;
      ALUOP_FN: begin
        case (funct3)
          // op5 separates R-type from I-ALU so addi ignores funct7b5
          3'b000:  ALUControl = (op5 && funct7b5) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
          3'b010:  ALUControl = ALU_CTRL_SLT;
          3'b110:  ALUControl = ALU_CTRL_OR;
          3'b111:  ALUControl = ALU_CTRL_AND;
          default: begin
            ALUControl = ALU_CTRL_ADD;
            illegal    = 1'b1;
          end
        endcase
      end
      default: ALUControl = ALU_CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> execute -> writeback,
// stalling on a unified memory via MemReady.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE      = S_FETCH,
  parameter bit     UNSUPPORTED_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Error
);

  state_t     state_q, state_d;
  logic       Error_q, Error_d;
  logic [1:0] ALUOp;
  logic       illegal_f3;
  logic       op_known;
  logic       in_exec;

  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_IALU) || (op == OP_BEQ) || (op == OP_JAL);
  assign in_exec  = (state_q == S_EXECR) || (state_q == S_EXECI);

  alu_decoder u_alu_dec (
    .ALUOp      (ALUOp),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .ALUControl (ALUControl),
    .illegal    (illegal_f3)
  );

  // State and sticky error registers; reset abandons any pending access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      Error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      Error_q <= Error_d;
    end
  end

  // Next-state and sticky error update
  always_comb begin
    state_d = state_q;
    Error_d = Error_q | (in_exec && illegal_f3) |
              ((state_q == S_DECODE) && !op_known);
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_IALU:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = UNSUPPORTED_TRAP ? S_ERROR : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs; FETCH enables follow MemReady (masked in reset), BEQ follows Zero
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ImmSrc    = IMM_I;
    RegWrite  = 1'b0;
    ALUOp     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        PCWrite   = MemReady && rst_n;
        IRWrite   = MemReady && rst_n;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_FN;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FN;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_SUB;
        PCWrite = Zero;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign Error = Error_q;

endmodule
